// File: rtl/sample_buffer.sv
// Timestamped sample capture FIFO: each sample_ce strobe queues {sample_data, ts}
// into a first-word-fall-through buffer drained over a valid/ready stream.
module sample_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int TS_WIDTH   = 32,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_ce,
    input  logic [DATA_WIDTH-1:0] sample_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [TS_WIDTH-1:0]   m_timestamp,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic [15:0]           dropped_cnt
);
    localparam int PTR_W = $clog2(DEPTH);

    // Stream handshake: an entry transfers on any rising edge where m_valid and
    // m_ready are both 1; m_valid never depends on m_ready in the same cycle,
    // and m_data/m_timestamp hold while m_valid=1 and m_ready=0.

    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [TS_WIDTH-1:0]   ts_mem   [DEPTH];
    logic [TS_WIDTH-1:0]   ts;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_next;
    logic                  full;
    logic                  pop;
    logic                  push_acc;
    logic                  drop;

    assign full     = (count == CNT_W'(DEPTH));
    assign pop      = m_valid & m_ready;
    // A pop in the same cycle frees the slot the push lands in, so a full FIFO still accepts.
    assign push_acc = sample_ce & (~full | pop);
    assign drop     = sample_ce & full & ~pop;

    always_comb begin
        count_next = count + CNT_W'(push_acc) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts      <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            m_valid <= 1'b0;
        end else begin
            ts    <= ts + TS_WIDTH'(1);
            count <= count_next;
            // Registered copy of (count != 0) keeps m_valid a plain flop output.
            m_valid <= (count_next != '0);
            if (push_acc) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)      rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            data_mem[wr_ptr] <= sample_data;
            ts_mem[wr_ptr]   <= ts;
        end
    end

    assign m_data      = data_mem[rd_ptr];
    assign m_timestamp = ts_mem[rd_ptr];

    // A drop in the same cycle as a clear wins: the new drop is the first one counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow    <= 1'b0;
            dropped_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (overflow_clr)
                dropped_cnt <= 16'd1;
            else if (dropped_cnt != 16'hFFFF)
                dropped_cnt <= dropped_cnt + 16'd1;
        end else if (overflow_clr) begin
            overflow    <= 1'b0;
            dropped_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_sample_buffer.sv
// Bench for sample_buffer: directed strobes push {data, ts} into an expected
// queue; a negedge monitor pops and compares on every accepted transfer.
module tb_sample_buffer;
    localparam int DW = 16;
    localparam int TW = 32;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_ce = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [TW-1:0] m_timestamp;
    logic [CW-1:0] count;
    logic          overflow;
    logic          overflow_clr = 1'b0;
    logic [15:0]   dropped_cnt;

    int tests  = 0;
    int errors = 0;

    logic [DW+TW-1:0] exp_q[$];
    logic [TW-1:0]    cyc;

    sample_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .sample_ce    (sample_ce),
        .sample_data  (sample_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_timestamp  (m_timestamp),
        .count        (count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .dropped_cnt  (dropped_cnt)
    );

    // clock/reset block
    always #5 clk = ~clk;

    // reference cycle counter: equals the expected ts value in the current cycle
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 32'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", 32'd1, 32'd0);
            end else begin
                logic [DW+TW-1:0] e;
                e = exp_q.pop_front();
                check("pop_data", {16'd0, m_data}, {16'd0, e[DW+TW-1:TW]});
                check("pop_ts", m_timestamp, e[TW-1:0]);
            end
        end
    end

    // driver tasks: all called at posedge+#1
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [DW-1:0] d, input bit acc);
        sample_ce   = 1'b1;
        sample_data = d;
        if (acc) exp_q.push_back({d, cyc});
        step();
        sample_ce = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        m_ready = 1'b1;
        while (count != 0 && n < 64) begin
            step();
            n++;
        end
        m_ready = 1'b0;
        check("drain_timeout", 32'(n < 64), 32'd1);
        check("drain_valid", {31'd0, m_valid}, 32'd0);
    endtask

    task automatic fill16(input int gap);
        for (int i = 0; i < 16; i++) begin
            strobe(DW'(i), 1'b1);
            for (int g = 1; g < gap; g++) step();
        end
    endtask

    initial begin
        // reset
        #12;
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_count", {27'd0, count}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_dropped", {16'd0, dropped_cnt}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // single strobe at ts=5, held while m_ready=0
        repeat (5) step();
        check("ts_model_5", cyc, 32'd5);
        strobe(16'h1234, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, m_valid}, 32'd1);
            check("hold_data", {16'd0, m_data}, 32'h1234);
            check("hold_ts", m_timestamp, 32'd5);
            check("hold_count", {27'd0, count}, 32'd1);
        end
        step();
        drain();

        // 16 strobes spaced by 3, then full-FIFO drops and clear
        fill16(3);
        check("full_count", {27'd0, count}, 32'd16);
        check("full_overflow", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 3; i++) strobe(16'hDEAD, 1'b0);
        check("drop_cnt3", {16'd0, dropped_cnt}, 32'd3);
        check("drop_overflow", {31'd0, overflow}, 32'd1);
        check("drop_count", {27'd0, count}, 32'd16);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        check("clr_overflow", {31'd0, overflow}, 32'd0);
        check("clr_dropped", {16'd0, dropped_cnt}, 32'd0);

        // clear and drop in the same cycle: the set wins
        overflow_clr = 1'b1;
        strobe(16'hBEEF, 1'b0);
        overflow_clr = 1'b0;
        check("clrdrop_overflow", {31'd0, overflow}, 32'd1);
        check("clrdrop_dropped", {16'd0, dropped_cnt}, 32'd1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;

        // full with simultaneous push and pop
        m_ready = 1'b1;
        strobe(16'h00AA, 1'b1);
        m_ready = 1'b0;
        check("fullpp_count", {27'd0, count}, 32'd16);
        check("fullpp_dropped", {16'd0, dropped_cnt}, 32'd0);
        check("fullpp_overflow", {31'd0, overflow}, 32'd0);
        check("fullpp_head", {16'd0, m_data}, 32'd1);
        drain();
        check("drain_count", {27'd0, count}, 32'd0);

        // streaming: strobe every cycle with m_ready=1
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            strobe(16'h0100 + DW'(i), 1'b1);
            check("stream_count", {27'd0, count}, 32'd1);
            check("stream_valid", {31'd0, m_valid}, 32'd1);
        end
        step();
        check("stream_end_count", {27'd0, count}, 32'd0);
        m_ready = 1'b0;

        // asynchronous reset mid-cycle with 5 queued entries
        for (int i = 0; i < 5; i++) strobe(16'h0200 + DW'(i), 1'b1);
        check("pre_rst_count", {27'd0, count}, 32'd5);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        check("arst_valid", {31'd0, m_valid}, 32'd0);
        check("arst_count", {27'd0, count}, 32'd0);
        check("arst_dropped", {16'd0, dropped_cnt}, 32'd0);
        step();
        rst = 1'b0;
        strobe(16'h0777, 1'b1);
        @(negedge clk);
        check("post_rst_ts", m_timestamp, 32'd0);
        check("post_rst_data", {16'd0, m_data}, 32'h0777);
        step();
        drain();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
